// File: rtl/dual_down_counter.sv
// dual_down_counter: two-channel programmable down-counter/timer.
// Channel 0 decrements on each enabled cycle. Channel 1 decrements once every
// PRESCALE enabled cycles. Each channel pulses Done for one cycle on a 1 -> 0
// transition and can optionally reload its last loaded value when it sits at zero.
module dual_down_counter #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Slt,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] Count0,
    output logic [WIDTH-1:0] Count1,
    output logic             Zero0,
    output logic             Zero1,
    output logic             Done0,
    output logic             Done1
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] r_count0;
    logic [WIDTH-1:0] r_count1;
    logic [WIDTH-1:0] r_rel0;
    logic [WIDTH-1:0] r_rel1;
    logic [PW-1:0]    r_pre;
    logic             r_done0;
    logic             r_done1;

    logic             w_zero0;
    logic             w_zero1;
    logic             w_act0;
    logic             w_act1;
    logic             w_idle1;
    logic             w_pre_last;
    logic             w_tick0;
    logic             w_tick1;
    logic [WIDTH-1:0] w_next0;
    logic [WIDTH-1:0] w_next1;

    // Tick qualification and next-count selection for both channels
    always_comb begin
        w_zero0    = (r_count0 == '0);
        w_zero1    = (r_count1 == '0);
        w_act0     = En & ~Load & ~Slt;
        w_act1     = En & ~Load & Slt;
        // An idle channel 1 has nothing to count toward, so the prescaler stalls
        w_idle1    = w_zero1 & (~AutoReload | (r_rel1 == '0));
        w_pre_last = (r_pre == PRE_LAST);
        w_tick0    = w_act0;
        w_tick1    = w_act1 & ~w_idle1 & w_pre_last;
        // Zero reloads the stored value when enabled; a stored zero keeps it at zero
        w_next0    = w_zero0 ? (AutoReload ? r_rel0 : '0) : (r_count0 - WIDTH'(1));
        w_next1    = w_zero1 ? (AutoReload ? r_rel1 : '0) : (r_count1 - WIDTH'(1));
    end

    // Channel 0 count, reload value and Done pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count0 <= '0;
            r_rel0   <= '0;
            r_done0  <= 1'b0;
        end else if (Load && !Slt) begin
            r_count0 <= LoadVal;
            r_rel0   <= LoadVal;
            r_done0  <= 1'b0;
        end else begin
            r_done0 <= w_tick0 && (r_count0 == WIDTH'(1));
            if (w_tick0) begin
                r_count0 <= w_next0;
            end
        end
    end

    // Channel 1 count, reload value, prescaler and Done pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count1 <= '0;
            r_rel1   <= '0;
            r_pre    <= '0;
            r_done1  <= 1'b0;
        end else if (Load && Slt) begin
            r_count1 <= LoadVal;
            r_rel1   <= LoadVal;
            r_pre    <= '0;
            r_done1  <= 1'b0;
        end else begin
            r_done1 <= w_tick1 && (r_count1 == WIDTH'(1));
            if (w_act1 && !w_idle1) begin
                r_pre <= w_pre_last ? '0 : (r_pre + PW'(1));
            end
            if (w_tick1) begin
                r_count1 <= w_next1;
            end
        end
    end

    assign Count0 = r_count0;
    assign Count1 = r_count1;
    assign Zero0  = w_zero0;
    assign Zero1  = w_zero1;
    assign Done0  = r_done0;
    assign Done1  = r_done1;

endmodule

// File: doc/dual_down_counter.md
Name: dual_down_counter

Overview:
- Two-channel 64-bit programmable down-counter/timer. It is the countdown counterpart of the team's dual up-counter block, using the same Slt/En channel-select scheme.
- Channel 0 decrements once per enabled cycle. Channel 1 decrements once per PRESCALE enabled cycles.
- Each channel raises a one-cycle Done pulse on reaching zero and can optionally auto-reload its last loaded value.
- Used as a timeout/event source alongside the up-counter in the test datapath.

Parameters:
WIDTH, 64, counter and load-value width.
PRESCALE, 4, enabled Slt=1 cycles per channel-1 decrement (must be >= 2).

Ports:
Clk  input  1  clock; all state changes on rising edge.
Reset  input  1  synchronous, active-high reset.
Slt  input  1  channel select: 0 = channel 0, 1 = channel 1 (applies to Load and En).
En  input  1  count enable for the selected channel.
Load  input  1  load LoadVal into the selected channel.
LoadVal  input  WIDTH  value to load.
AutoReload  input  1  1 = a channel sitting at zero reloads its stored value on its next tick.
Count0  output  WIDTH  channel 0 count.
Count1  output  WIDTH  channel 1 count.
Zero0  output  1  Count0 == 0 (combinational).
Zero1  output  1  Count1 == 0 (combinational).
Done0  output  1  registered one-cycle pulse when Count0 goes 1 -> 0.
Done1  output  1  registered one-cycle pulse when Count1 goes 1 -> 0.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high; it is sampled only on the rising edge of Clk.
- Reset values:
  - Count0 = Count1 = 0; Zero0 = Zero1 = 1; Done0 = Done1 = 0.
  - Internal reload registers Rel0 = Rel1 = 0; prescaler Pre = 0.
  - Power-up (initial) state equals the reset state.
- Priority per edge: Reset > Load > En. Only the channel selected by Slt is affected; the other channel holds all its state.
- Load (Reset=0, Load=1):
  - Count_sel <= LoadVal and Rel_sel <= LoadVal.
  - If Slt=1, also Pre <= 0.
  - No decrement that cycle; Done outputs 0 that cycle.
  - Loading 0 is legal: the channel is idle and no Done is generated.
- Tick: channel 0 ticks on every edge with En=1, Load=0, Slt=0. Channel 1 ticks on an En=1, Load=0, Slt=1 edge where Pre == PRESCALE-1.
- Prescaler (En=1, Load=0, Slt=1):
  - If Pre == PRESCALE-1: Pre <= 0 and channel 1 ticks.
  - Otherwise: Pre <= Pre + 1.
  - Pre is frozen while channel 1 is idle (Count1 == 0 and (AutoReload == 0 or Rel1 == 0)).
- Tick action per channel:
  - Count > 1: decrement by 1.
  - Count == 1: becomes 0; Done registered high for exactly the next cycle.
  - Count == 0 with AutoReload=1 and Rel != 0: Count <= Rel; no Done.
  - Count == 0 otherwise: hold at 0. No wrap-around to all-ones, ever.
- Done0/Done1 are 0 on every edge without a qualifying 1 -> 0 transition. Consecutive pulses are possible only with reload value 1 (pattern 1, 0, 1, 0).
- En=0: all state holds, including Pre.
- Reset mid-countdown clears everything and suppresses any pending Done.
- Arithmetic: unsigned WIDTH-bit. The Slt=1 cycles that did not tick channel 1 never touch Count0.

Test Plan:
- Reset; Load Slt=0 LoadVal=3; then 4 edges En=1 Slt=0 -> Count0 = 3,2,1,0,0; Done0 high only in the cycle Count0 first reads 0; Zero0=1 thereafter; Count1 stays 0.
- Load Slt=1 LoadVal=2; then 8 edges En=1 Slt=1 -> Count1 = 2 until the 4th edge, 1 after the 4th, 0 after the 8th; Done1 exactly one pulse after the 8th edge; Count0 unchanged.
- AutoReload=1; Load Slt=0 LoadVal=2; then 5 edges En=1 Slt=0 -> Count0 = 2,1,0,2,1,0; Done0 pulses twice; reload edge produces no Done.
- Load=1 and En=1 on the same edge, Slt=0, LoadVal=7 -> Count0 = 7, no decrement. Then En=0 for 3 edges -> Count0 holds at 7, Done0 = 0.
- Count0=1 with En=1 Reset=1 on the same edge -> Count0 = 0, Done0 = 0. All outputs return to reset values.
- AutoReload=0, Count1=0: 3 edges En=1 Slt=1 (Pre frozen at 0); then Load Slt=1 LoadVal=1; then 4 edges En=1 Slt=1 -> Done1 pulses only after the 4th edge.
